// File: rtl/vm2_irq_pkg.sv
// rtl/vm2_irq_pkg.sv - shared types and constants for the VM2 vectored interrupt controller
package vm2_irq_pkg;

   localparam int VEC_W = 16;
   localparam logic [VEC_W-1:0] SPUR_VEC_DEF = 16'o000000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      ACK  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/vm2_irq_ctrl_if.sv
// rtl/vm2_irq_ctrl_if.sv - CPU-side vector handshake (virq/ivec/istb/iack)
interface vm2_irq_ctrl_if;
   import vm2_irq_pkg::*;

   logic             virq_o;
   logic [VEC_W-1:0] ivec_o;
   logic             istb_i;
   logic             iack_o;

   modport master (output istb_i, input virq_o, input ivec_o, input iack_o);
   modport slave  (input istb_i, output virq_o, output ivec_o, output iack_o);

endinterface

// File: rtl/vm2_irq_ctrl_prio_enc.sv
// rtl/vm2_irq_ctrl_prio_enc.sv - rotating-start priority encoder; the first active
// request found scanning upward from start (mod N) wins
module irq_prio_enc #(
   parameter int N     = 8,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] win,
   output logic             any
);

   always_comb begin
      win = '0;
      any = |req;
      // Scan from the far end so the earliest candidate in search order overwrites last
      for (int i = N - 1; i >= 0; i--) begin
         int idx;
         idx = (int'(start) + i) % N;
         if (req[idx]) win = IDX_W'(idx);
      end
   end

endmodule

// File: rtl/vm2_irq_ctrl.sv
// rtl/vm2_irq_ctrl.sv - vectored interrupt controller feeding the VM2 CPU; optional
// rotating priority with VM2_IRQ_ROUND_ROBIN_EN
module vm2_irq_ctrl
   import vm2_irq_pkg::*;
#(
   parameter int               N        = 8,
   parameter logic [VEC_W-1:0] SPUR_VEC = SPUR_VEC_DEF
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [N-1:0]     irq_i,
   input  logic [VEC_W*N-1:0] vec_i,
   output logic [N-1:0]     irq_ack_o,
   vm2_irq_ctrl_if.slave    cpu
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   state_t           state, state_n;
   logic             virq_q, virq_n;
   logic             iack_q, iack_n;
   logic [VEC_W-1:0] ivec_q, ivec_n;
   logic [N-1:0]     ack_q, ack_n;
   logic [IDX_W-1:0] start;
   logic [IDX_W-1:0] win;
   logic             any;

`ifdef VM2_IRQ_ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_ptr, rr_n;
   assign start = rr_ptr;
`else
   assign start = '0;
`endif

   irq_prio_enc #(.N(N), .IDX_W(IDX_W)) u_prio (
      .req   (irq_i),
      .start (start),
      .win   (win),
      .any   (any)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state  <= IDLE;
         virq_q <= 1'b0;
         iack_q <= 1'b0;
         ivec_q <= '0;
         ack_q  <= '0;
`ifdef VM2_IRQ_ROUND_ROBIN_EN
         rr_ptr <= '0;
`endif
      end else begin
         state  <= state_n;
         virq_q <= virq_n;
         iack_q <= iack_n;
         ivec_q <= ivec_n;
         ack_q  <= ack_n;
`ifdef VM2_IRQ_ROUND_ROBIN_EN
         rr_ptr <= rr_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      virq_n  = virq_q;
      iack_n  = iack_q;
      ivec_n  = ivec_q;
      ack_n   = '0;
`ifdef VM2_IRQ_ROUND_ROBIN_EN
      rr_n    = rr_ptr;
`endif
      case (state)
         IDLE: begin
            if (cpu.istb_i) begin
               ivec_n  = SPUR_VEC;
               iack_n  = 1'b1;
               state_n = ACK;
            end else if (any) begin
               virq_n  = 1'b1;
               state_n = PEND;
            end
         end
         PEND: begin
            if (cpu.istb_i) begin
               virq_n  = 1'b0;
               iack_n  = 1'b1;
               state_n = ACK;
               // Winner is committed here; later irq_i changes cannot disturb ivec
               if (any) begin
                  ivec_n     = vec_i[VEC_W*int'(win) +: VEC_W];
                  ack_n[win] = 1'b1;
`ifdef VM2_IRQ_ROUND_ROBIN_EN
                  rr_n = (win == IDX_W'(N - 1)) ? '0 : win + 1'b1;
`endif
               end else begin
                  ivec_n = SPUR_VEC;
               end
            end else if (!any) begin
               virq_n  = 1'b0;
               state_n = IDLE;
            end
         end
         ACK: begin
            if (!cpu.istb_i) begin
               iack_n  = 1'b0;
               state_n = DONE;
            end
         end
         DONE: begin
            // Lets the granted peripheral's request clear reach irq_i before re-arbitration
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign irq_ack_o  = ack_q;
   assign cpu.virq_o = virq_q;
   assign cpu.iack_o = iack_q;
   assign cpu.ivec_o = ivec_q;

endmodule

// File: tb/tb_vm2_irq_ctrl.sv
// tb/tb_vm2_irq_ctrl.sv - scoreboard bench for vm2_irq_ctrl
module tb_vm2_irq_ctrl;
   import vm2_irq_pkg::*;

   localparam int N = 8;

   logic               wb_clk_i = 1'b0;
   logic               wb_rst_i;
   logic [N-1:0]       irq_i;
   logic [VEC_W*N-1:0] vec_i;
   logic [N-1:0]       irq_ack_o;

   vm2_irq_ctrl_if cpu_if ();

   vm2_irq_ctrl #(.N(N), .SPUR_VEC(SPUR_VEC_DEF)) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .irq_i     (irq_i),
      .vec_i     (vec_i),
      .irq_ack_o (irq_ack_o),
      .cpu       (cpu_if)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct {
      logic [VEC_W-1:0] vec;
      logic [N-1:0]     ack;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   function automatic logic [VEC_W-1:0] vec_of(input int ch);
      if (ch == 3) return 16'o000060;
      return 16'o000100 + 16'(ch * 4);
   endfunction

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic pulse_reset();
      irq_i = '0;
      cpu_if.istb_i = 1'b0;
      wb_rst_i = 1'b1;
      tick();
      wb_rst_i = 1'b0;
   endtask

   task automatic push_exp(input logic [VEC_W-1:0] v, input logic [N-1:0] a);
      exp_t e;
      e.vec = v;
      e.ack = a;
      sb.push_back(e);
   endtask

   task automatic wait_virq(input string name);
      int k = 0;
      while (cpu_if.virq_o !== 1'b1 && k < 10) begin
         tick();
         k++;
      end
      n_cmp++;
      if (cpu_if.virq_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_virq_wait: virq=%b required 1", name, cpu_if.virq_o);
      end
   endtask

   // Drives one vector read (istb held 3 cycles), pops the scoreboard at grant time
   task automatic do_read(input string name, input logic [N-1:0] clr);
      exp_t e;
      cpu_if.istb_i = 1'b1;
      tick();
      n_cmp++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s_sb_empty: no expected entry", name);
         cpu_if.istb_i = 1'b0;
         return;
      end
      e = sb.pop_front();
      n_cmp++;
      if (cpu_if.iack_o !== 1'b1) begin
         n_fail++; $display("FAIL %s_iack: got %b required 1", name, cpu_if.iack_o);
      end
      n_cmp++;
      if (cpu_if.ivec_o !== e.vec) begin
         n_fail++; $display("FAIL %s_ivec: got %o required %o", name, cpu_if.ivec_o, e.vec);
      end
      n_cmp++;
      if (irq_ack_o !== e.ack) begin
         n_fail++; $display("FAIL %s_irq_ack: got %b required %b", name, irq_ack_o, e.ack);
      end
      n_cmp++;
      if (cpu_if.virq_o !== 1'b0) begin
         n_fail++; $display("FAIL %s_virq_at_grant: got %b required 0", name, cpu_if.virq_o);
      end
      irq_i = irq_i & ~clr;
      tick();
      n_cmp++;
      if (irq_ack_o !== '0 || cpu_if.iack_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_pulse_hold: irq_ack=%b iack=%b required 0/1", name, irq_ack_o, cpu_if.iack_o);
      end
      tick();
      cpu_if.istb_i = 1'b0;
      tick();
      n_cmp++;
      if (cpu_if.iack_o !== 1'b0) begin
         n_fail++; $display("FAIL %s_iack_drop: got %b required 0", name, cpu_if.iack_o);
      end
      tick();
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      irq_i = '0;
      cpu_if.istb_i = 1'b0;
      #12;
      n_cmp++;
      if ({cpu_if.virq_o, cpu_if.iack_o, cpu_if.ivec_o, irq_ack_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: virq=%b iack=%b ivec=%o irq_ack=%b required all 0",
                  cpu_if.virq_o, cpu_if.iack_o, cpu_if.ivec_o, irq_ack_o);
      end
      tick();
      wb_rst_i = 1'b0;
   endtask

   task automatic test_single();
      pulse_reset();
      irq_i[3] = 1'b1;
      tick();
      n_cmp++;
      if (cpu_if.virq_o !== 1'b1) begin
         n_fail++; $display("FAIL single_virq_latency: got %b required 1", cpu_if.virq_o);
      end
      push_exp(vec_of(3), 8'b0000_1000);
      do_read("single", 8'b0000_1000);
      tick();
      n_cmp++;
      if (cpu_if.virq_o !== 1'b0) begin
         n_fail++; $display("FAIL single_virq_after: got %b required 0", cpu_if.virq_o);
      end
   endtask

   task automatic test_simultaneous();
      pulse_reset();
      irq_i = 8'b0010_0010;
      wait_virq("simul1");
      push_exp(vec_of(1), 8'b0000_0010);
      do_read("simul1", 8'b0000_0010);
      wait_virq("simul5");
      push_exp(vec_of(5), 8'b0010_0000);
      do_read("simul5", 8'b0010_0000);
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      irq_i = 8'b0010_0010;
`ifdef VM2_IRQ_ROUND_ROBIN_EN
      for (int k = 0; k < 4; k++) begin
         wait_virq("rr");
         if (k % 2 == 0) push_exp(vec_of(1), 8'b0000_0010);
         else            push_exp(vec_of(5), 8'b0010_0000);
         do_read("rr", '0);
      end
`else
      for (int k = 0; k < 2; k++) begin
         wait_virq("regrant");
         push_exp(vec_of(1), 8'b0000_0010);
         do_read("regrant", '0);
      end
`endif
      irq_i = '0;
      tick();
   endtask

   task automatic test_withdraw();
      logic [N-1:0] seen;
      pulse_reset();
      seen = '0;
      irq_i[2] = 1'b1;
      tick();
      seen |= irq_ack_o;
      n_cmp++;
      if (cpu_if.virq_o !== 1'b1) begin
         n_fail++; $display("FAIL withdraw_virq_rise: got %b required 1", cpu_if.virq_o);
      end
      tick();
      seen |= irq_ack_o;
      irq_i = '0;
      tick();
      seen |= irq_ack_o;
      n_cmp++;
      if (cpu_if.virq_o !== 1'b0) begin
         n_fail++; $display("FAIL withdraw_virq_fall: got %b required 0", cpu_if.virq_o);
      end
      n_cmp++;
      if (seen !== '0) begin
         n_fail++; $display("FAIL withdraw_no_ack: got %b required 0", seen);
      end
   endtask

   task automatic test_spurious();
      irq_i = '0;
      push_exp(SPUR_VEC_DEF, '0);
      do_read("spurious", '0);
   endtask

   task automatic test_preempt();
      pulse_reset();
      irq_i[6] = 1'b1;
      wait_virq("preempt");
      tick();
      irq_i[0] = 1'b1;
      tick();
      tick();
      push_exp(vec_of(0), 8'b0000_0001);
      do_read("preempt", 8'b0100_0001);
   endtask

   task automatic test_reset_mid_ack();
      pulse_reset();
      irq_i[4] = 1'b1;
      wait_virq("rst_mid");
      cpu_if.istb_i = 1'b1;
      tick();
      n_cmp++;
      if (cpu_if.iack_o !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_iack_before: got %b required 1", cpu_if.iack_o);
      end
      #2;
      wb_rst_i = 1'b1;
      #1;
      n_cmp++;
      if ({cpu_if.virq_o, cpu_if.iack_o, cpu_if.ivec_o, irq_ack_o} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_async: virq=%b iack=%b ivec=%o irq_ack=%b required all 0",
                  cpu_if.virq_o, cpu_if.iack_o, cpu_if.ivec_o, irq_ack_o);
      end
      cpu_if.istb_i = 1'b0;
      tick();
      wb_rst_i = 1'b0;
      tick();
      n_cmp++;
      if (cpu_if.virq_o !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_virq_reraise: got %b required 1", cpu_if.virq_o);
      end
      irq_i = '0;
      tick();
      tick();
   endtask

   initial begin
      for (int i = 0; i < N; i++) vec_i[VEC_W*i +: VEC_W] = vec_of(i);
      cpu_if.istb_i = 1'b0;
      test_reset();
      test_single();
      test_simultaneous();
      test_back_to_back();
      test_withdraw();
      test_spurious();
      test_preempt();
      test_reset_mid_ack();
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL sb_leftover: got %0d entries required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
